// File: rtl/mips_debug_loader_if.sv
// Bus bundle between the debug loader and its surroundings: UART RX FIFO,
// program-memory write port, core control and the debug dump unit.
interface mips_debug_loader_if #(
    parameter int INSTR_W = 32,
    parameter int ADDR_W  = 8,
    parameter int CYC_W   = 32
);
    logic               rx_empty;
    logic [7:0]         rx_data;
    logic               rd_uart;
    logic               pm_we;
    logic [ADDR_W-1:0]  pm_addr;
    logic [INSTR_W-1:0] pm_data;
    logic               cpu_en;
    logic               cpu_rst;
    logic               finished;
    logic               dump_req;
    logic               dump_done;
    logic               timeout;
    logic [CYC_W-1:0]   cycles;
    logic [2:0]         state;

    // Loader side
    modport master (
        input  rx_empty, rx_data, finished, dump_done,
        output rd_uart, pm_we, pm_addr, pm_data, cpu_en, cpu_rst,
               dump_req, timeout, cycles, state
    );

    // Environment side (FIFO, memory, core, dump unit)
    modport slave (
        output rx_empty, rx_data, finished, dump_done,
        input  rd_uart, pm_we, pm_addr, pm_data, cpu_en, cpu_rst,
               dump_req, timeout, cycles, state
    );
endinterface

// File: rtl/mips_debug_loader.sv
// UART-driven program loader and run/step controller for the MIPS core.
// Bytes arrive MSB-first and are packed into words written to program memory;
// afterwards single-byte commands run, step, reset or reload the core, and each
// run/step ends with a request to the debug dump unit.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  WAIT_LEN | waiting for a non-zero word count byte
//  LOAD     | assembling bytes into words and writing program memory
//  WAIT_OP  | waiting for a command byte ('1' run, '2' step, '3' load, '4' reset)
//  RUN      | core enabled until halt, watchdog limit or ESC
//  STEP     | one enabled cycle (none if the core is already halted)
//  DUMP     | debug unit sending state; wait for its done
module mips_debug_loader #(
    parameter int INSTR_W    = 32,
    parameter int ADDR_W     = 8,
    parameter int CYC_W      = 32,
    parameter int MAX_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    mips_debug_loader_if.master bus
);
    localparam int BPW  = INSTR_W / 8;
    localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [7:0] CMD_RUN  = 8'h31;
    localparam logic [7:0] CMD_STEP = 8'h32;
    localparam logic [7:0] CMD_LOAD = 8'h33;
    localparam logic [7:0] CMD_RST  = 8'h34;
    localparam logic [7:0] ESC      = 8'h1B;

    localparam logic [CYC_W-1:0] RUN_LAST = CYC_W'(MAX_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_SAT  = '1;
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BPW - 1);

    typedef enum logic [2:0] {
        WAIT_LEN = 3'd0,
        LOAD     = 3'd1,
        WAIT_OP  = 3'd2,
        RUN      = 3'd3,
        STEP     = 3'd4,
        DUMP     = 3'd5
    } state_t;

    state_t             state;
    logic [7:0]         n_words;
    logic [7:0]         word_idx;
    logic [BC_W-1:0]    byte_cnt;
    logic [INSTR_W-1:0] asm_word;
    logic               load_done;
    logic [CYC_W-1:0]   run_cnt;
    logic [CYC_W-1:0]   cycles;
    logic               pm_we;
    logic [ADDR_W-1:0]  pm_addr;
    logic [INSTR_W-1:0] pm_data;
    logic               cpu_rst;
    logic               dump_req;
    logic               timeout;

    logic               rd_uart;
    logic               cpu_en;
    logic               esc_head;
    logic               run_last;
    logic               word_in_range;
    logic [INSTR_W-1:0] next_word;

    // FIFO pop and core enable must react in the same cycle as the byte / halt flag.
    // In RUN an ESC loses to a simultaneous halt or to the final watchdog cycle.
    always_comb begin
        esc_head      = !bus.rx_empty && (bus.rx_data == ESC);
        run_last      = (run_cnt == RUN_LAST);
        next_word     = (asm_word << 8) | INSTR_W'(bus.rx_data);
        word_in_range = (({1'b0, word_idx} >> ADDR_W) == 9'd0);
        rd_uart       = 1'b0;
        cpu_en        = 1'b0;
        case (state)
            WAIT_LEN, WAIT_OP: rd_uart = !bus.rx_empty;
            LOAD:              rd_uart = !bus.rx_empty && !load_done;
            RUN: begin
                rd_uart = esc_head && !bus.finished && !run_last;
                cpu_en  = !bus.finished && !rd_uart;
            end
            STEP:              cpu_en = !bus.finished;
            default: ;
        endcase
    end

    // Control FSM with registered strobes, memory port and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_LEN;
            n_words   <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            asm_word  <= '0;
            load_done <= 1'b0;
            run_cnt   <= '0;
            cycles    <= '0;
            pm_we     <= 1'b0;
            pm_addr   <= '0;
            pm_data   <= '0;
            cpu_rst   <= 1'b0;
            dump_req  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            pm_we    <= 1'b0;
            cpu_rst  <= 1'b0;
            dump_req <= 1'b0;
            if (cpu_en && (cycles != CYC_SAT)) begin
                cycles <= cycles + CYC_W'(1);
            end
            case (state)
                WAIT_LEN: begin
                    if (rd_uart && (bus.rx_data != 8'h00)) begin
                        n_words   <= bus.rx_data;
                        word_idx  <= '0;
                        byte_cnt  <= '0;
                        asm_word  <= '0;
                        load_done <= 1'b0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (load_done) begin
                        // The last word was written in the previous cycle.
                        cpu_rst   <= 1'b1;
                        cycles    <= '0;
                        timeout   <= 1'b0;
                        load_done <= 1'b0;
                        state     <= WAIT_OP;
                    end else if (rd_uart) begin
                        asm_word <= next_word;
                        if (byte_cnt == BC_LAST) begin
                            byte_cnt <= '0;
                            pm_we    <= word_in_range;
                            pm_addr  <= ADDR_W'(word_idx);
                            pm_data  <= next_word;
                            word_idx <= word_idx + 8'd1;
                            if (word_idx == (n_words - 8'd1)) begin
                                load_done <= 1'b1;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                WAIT_OP: begin
                    if (rd_uart) begin
                        case (bus.rx_data)
                            CMD_RUN: begin
                                timeout <= 1'b0;
                                run_cnt <= '0;
                                state   <= RUN;
                            end
                            CMD_STEP: state <= STEP;
                            CMD_LOAD: state <= WAIT_LEN;
                            CMD_RST: begin
                                cpu_rst <= 1'b1;
                                cycles  <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cpu_en) begin
                        run_cnt <= run_cnt + CYC_W'(1);
                    end
                    if (bus.finished || rd_uart) begin
                        dump_req <= 1'b1;
                        state    <= DUMP;
                    end else if (run_last) begin
                        timeout  <= 1'b1;
                        dump_req <= 1'b1;
                        state    <= DUMP;
                    end
                end
                STEP: begin
                    dump_req <= 1'b1;
                    state    <= DUMP;
                end
                DUMP: begin
                    // A done seen while the request is still high is stale.
                    if (!dump_req && bus.dump_done) begin
                        state <= WAIT_OP;
                    end
                end
                default: state <= WAIT_LEN;
            endcase
        end
    end

    assign bus.rd_uart  = rd_uart;
    assign bus.cpu_en   = cpu_en;
    assign bus.pm_we    = pm_we;
    assign bus.pm_addr  = pm_addr;
    assign bus.pm_data  = pm_data;
    assign bus.cpu_rst  = cpu_rst;
    assign bus.dump_req = dump_req;
    assign bus.timeout  = timeout;
    assign bus.cycles   = cycles;
    assign bus.state    = state;
endmodule

// File: tb/tb_mips_debug_loader.sv
// Self-checking bench for mips_debug_loader: a byte-queue model of the RX FIFO,
// a write log for program memory and event counters feed directed checks.
module tb_mips_debug_loader;
    localparam int INSTR_W    = 32;
    localparam int ADDR_W     = 2;
    localparam int CYC_W      = 7;
    localparam int MAX_CYCLES = 64;
    localparam int DEPTH      = 1 << ADDR_W;
    localparam int CYC_SAT    = (1 << CYC_W) - 1;

    localparam logic [2:0] S_WAIT_LEN = 3'd0;
    localparam logic [2:0] S_WAIT_OP  = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_DUMP     = 3'd5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mips_debug_loader_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .CYC_W(CYC_W)) bus ();

    mips_debug_loader #(
        .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .CYC_W(CYC_W), .MAX_CYCLES(MAX_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]         rxq[$];
    logic [ADDR_W-1:0]  wr_addr[$];
    logic [INSTR_W-1:0] wr_data[$];
    int cyc = 0;
    int en_cnt = 0;
    int rst_cnt = 0;
    int dreq_cnt = 0;
    int esc_bad = 0;
    int last_we_cyc = 0;
    int last_rst_cyc = 0;

    // FIFO pop model: the byte at the head leaves when the DUT pops it.
    always @(posedge clk) begin
        cyc++;
        if (rst_n && bus.rd_uart && (rxq.size() > 0)) void'(rxq.pop_front());
    end

    // Present the FIFO head, then sample the DUT for the coming edge.
    always @(negedge clk) begin
        bus.rx_empty = (rxq.size() == 0);
        bus.rx_data  = (rxq.size() == 0) ? 8'h00 : rxq[0];
        #1;
        if (rst_n) begin
            if (bus.cpu_en) en_cnt++;
            if (bus.cpu_rst) begin rst_cnt++; last_rst_cyc = cyc; end
            if (bus.dump_req) dreq_cnt++;
            if (bus.pm_we) begin
                wr_addr.push_back(bus.pm_addr);
                wr_data.push_back(bus.pm_data);
                last_we_cyc = cyc;
            end
            if (bus.rd_uart && (bus.rx_data == 8'h1B) && bus.cpu_en) esc_bad++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int n = 0;
        while ((bus.state !== s) && (n < budget)) begin
            step();
            n++;
        end
        chk(tag, bus.state, s);
    endtask

    task automatic push_word(input logic [INSTR_W-1:0] w);
        for (int b = INSTR_W / 8 - 1; b >= 0; b--) rxq.push_back(w[b*8 +: 8]);
    endtask

    task automatic finish_dump(input string tag);
        bus.dump_done = 1'b1;
        step();
        step();
        bus.dump_done = 1'b0;
        wait_state(tag, S_WAIT_OP, 10);
    endtask

    int exp_cyc;
    int base_en, base_rst, base_dreq, base_wr, k, n;
    logic [7:0] g;
    logic [INSTR_W-1:0] words[6];
    logic [INSTR_W-1:0] w;

    initial begin
        bus.rx_empty  = 1'b1;
        bus.rx_data   = 8'h00;
        bus.finished  = 1'b0;
        bus.dump_done = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_state", bus.state, S_WAIT_LEN);
        chk("rst_pm_we", bus.pm_we, 0);
        chk("rst_cpu_en", bus.cpu_en, 0);
        chk("rst_cycles", bus.cycles, 0);
        chk("rst_timeout", bus.timeout, 0);
        rst_n = 1'b1;
        step();

        // Directed load with a leading zero count that must be ignored
        base_rst = rst_cnt;
        rxq.push_back(8'h00);
        rxq.push_back(8'h02);
        push_word(32'hAABBCCDD);
        push_word(32'h11223344);
        wait_state("load_done_state", S_WAIT_OP, 100);
        step();
        chk("load_we_count", wr_addr.size(), 2);
        chk("load_addr0", wr_addr[0], 0);
        chk("load_data0", wr_data[0], 32'hAABBCCDD);
        chk("load_addr1", wr_addr[1], 1);
        chk("load_data1", wr_data[1], 32'h11223344);
        chk("load_cpu_rst", rst_cnt - base_rst, 1);
        chk("load_rst_after_we", last_rst_cyc, last_we_cyc + 1);
        chk("load_rx_drained", rxq.size(), 0);
        exp_cyc = 0;
        chk("load_cycles", bus.cycles, exp_cyc);

        // Single step
        base_en = en_cnt; base_dreq = dreq_cnt;
        rxq.push_back(8'h32);
        wait_state("step_dump", S_DUMP, 10);
        step();
        exp_cyc = exp_cyc + 1;
        chk("step_en", en_cnt - base_en, 1);
        chk("step_cycles", bus.cycles, exp_cyc);
        chk("step_dump_req", dreq_cnt - base_dreq, 1);
        finish_dump("step_back");

        // Unknown command byte is consumed and ignored
        do g = 8'($urandom_range(0, 255)); while (g >= 8'h31 && g <= 8'h34);
        rxq.push_back(g);
        repeat (4) step();
        chk("junk_state", bus.state, S_WAIT_OP);
        chk("junk_drained", rxq.size(), 0);

        // Free run ending on halt after 50 enabled cycles
        base_en = en_cnt;
        rxq.push_back(8'h31);
        wait_state("run_enter", S_RUN, 10);
        n = 0;
        while ((en_cnt - base_en < 50) && (n < 500)) begin step(); n++; end
        bus.finished = 1'b1;
        wait_state("run_halt_dump", S_DUMP, 10);
        bus.finished = 1'b0;
        step();
        exp_cyc = exp_cyc + 50;
        chk("run_en", en_cnt - base_en, 50);
        chk("run_cycles", bus.cycles, exp_cyc);
        chk("run_timeout", bus.timeout, 0);
        finish_dump("run_back");

        // Watchdog
        base_en = en_cnt;
        rxq.push_back(8'h31);
        wait_state("wd_dump", S_DUMP, 200);
        step();
        exp_cyc = exp_cyc + MAX_CYCLES;
        chk("wd_en", en_cnt - base_en, MAX_CYCLES);
        chk("wd_timeout", bus.timeout, 1);
        chk("wd_cycles", bus.cycles, exp_cyc);
        finish_dump("wd_back");

        // Step with the core already halted: no enable, timeout stays sticky
        base_en = en_cnt;
        bus.finished = 1'b1;
        rxq.push_back(8'h32);
        wait_state("halted_step_dump", S_DUMP, 10);
        bus.finished = 1'b0;
        step();
        chk("halted_step_en", en_cnt - base_en, 0);
        chk("timeout_sticky", bus.timeout, 1);
        finish_dump("halted_step_back");

        // Run aborted by ESC; counter saturates
        base_en = en_cnt;
        rxq.push_back(8'h31);
        wait_state("esc_run_enter", S_RUN, 10);
        chk("run_clears_timeout", bus.timeout, 0);
        k = $urandom_range(10, 20);
        n = 0;
        while ((en_cnt - base_en < k) && (n < 100)) begin step(); n++; end
        rxq.push_back(8'h1B);
        wait_state("esc_dump", S_DUMP, 10);
        step();
        exp_cyc = (exp_cyc + k > CYC_SAT) ? CYC_SAT : exp_cyc + k;
        chk("esc_en", en_cnt - base_en, k);
        chk("esc_en_drop", esc_bad, 0);
        chk("esc_consumed", rxq.size(), 0);
        chk("esc_cycles_sat", bus.cycles, exp_cyc);
        finish_dump("esc_back");

        // CPU reset command
        base_rst = rst_cnt;
        rxq.push_back(8'h34);
        repeat (4) step();
        chk("cpurst_pulse", rst_cnt - base_rst, 1);
        chk("cpurst_cycles", bus.cycles, 0);
        chk("cpurst_state", bus.state, S_WAIT_OP);

        // Reload past the end of a 4-word memory: only in-range words written
        rxq.push_back(8'h33);
        wait_state("reload_wait_len", S_WAIT_LEN, 10);
        base_wr = wr_addr.size();
        rxq.push_back(8'd6);
        for (int i = 0; i < 6; i++) begin
            words[i] = $urandom();
            push_word(words[i]);
        end
        wait_state("big_load_done", S_WAIT_OP, 200);
        step();
        chk("big_we_count", wr_addr.size() - base_wr, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("big_addr%0d", i), wr_addr[base_wr + i], i);
            chk($sformatf("big_data%0d", i), wr_data[base_wr + i], words[i]);
        end
        chk("big_drained", rxq.size(), 0);

        // Reset in the middle of a word
        rxq.push_back(8'h33);
        rxq.push_back(8'h02);
        rxq.push_back(8'($urandom()));
        rxq.push_back(8'($urandom()));
        n = 0;
        while ((rxq.size() > 0) && (n < 50)) begin step(); n++; end
        chk("midword_state", bus.state, 3'd1);
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_state", bus.state, S_WAIT_LEN);
        chk("midrst_pm_we", bus.pm_we, 0);
        chk("midrst_pm_data", bus.pm_data, 0);
        chk("midrst_cpu_rst", bus.cpu_rst, 0);
        chk("midrst_dump_req", bus.dump_req, 0);
        chk("midrst_cycles", bus.cycles, 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        base_wr = wr_addr.size();
        w = $urandom();
        rxq.push_back(8'h01);
        push_word(w);
        wait_state("post_rst_load", S_WAIT_OP, 100);
        step();
        chk("post_rst_we", wr_addr.size() - base_wr, 1);
        chk("post_rst_addr", wr_addr[base_wr], 0);
        chk("post_rst_data", wr_data[base_wr], w);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
